// File: rtl/median_axis_out_backpressure_pkg.sv
// Shared types and width helpers for the median filter output stage.
package median_axis_out_backpressure_pkg;

  // Output sequencer: drop pixels until a frame start, then stream forever.
  typedef enum logic {
    WAIT_SOF,
    STREAM
  } out_state_t;

  // Counter width for a modulo-n counter (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/median_axis_out_backpressure_if.sv
// AXI4-Stream video output bundle (data, valid, tuser=SOF, tlast=EOL, ready).
interface median_axis_out_backpressure_if #(
  parameter int unsigned TDATA_W = 8
);
  logic [TDATA_W-1:0] m_axis_tdata;
  logic               m_axis_tvalid;
  logic               m_axis_tuser;
  logic               m_axis_tlast;
  logic               m_axis_tready;

  modport master (
    output m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast,
    input  m_axis_tready
  );

  modport slave (
    input  m_axis_tdata, m_axis_tvalid, m_axis_tuser, m_axis_tlast,
    output m_axis_tready
  );
endinterface

// File: rtl/median_sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a write while full is accepted
// only when a pop happens in the same cycle.
module median_sync_fifo #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_fire, rd_fire;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count   = wr_ptr_q - rd_ptr_q;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance for accepted writes and reads.
  always_comb begin
    wr_fire  = wr_en && (!full || rd_en);
    rd_fire  = rd_en && !empty;
    wr_ptr_d = wr_ptr_q + (AW+1)'(wr_fire);
    rd_ptr_d = rd_ptr_q + (AW+1)'(rd_fire);
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; when full with a pop, the slot being read is overwritten after it is consumed.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/median_axis_out_backpressure.sv
// Output stage for the median filter: buffers non-stallable core pixels,
// throttles the core by FIFO headroom and emits AXI4-Stream video with
// tuser/tlast regenerated from column/row counters.
module median_axis_out_backpressure
  import median_axis_out_backpressure_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CHANNELS     = 1,
  parameter int unsigned IMG_WIDTH    = 1280,
  parameter int unsigned IMG_HEIGHT   = 1024,
  parameter int unsigned PIPE_LATENCY = 6,
  parameter int unsigned FIFO_DEPTH   = 32
) (
  input  logic                             i_clk,
  input  logic                             i_aresetn,
  output logic                             o_in_tready,
  input  logic [CHANNELS*DATA_WIDTH-1:0]   i_pix_data,
  input  logic                             i_pix_valid,
  input  logic                             i_pix_sof,
  median_axis_out_backpressure_if.master   m_axis,
  output logic [$clog2(FIFO_DEPTH):0]      o_fill_level,
  output logic                             o_overflow,
  output logic                             o_frame_err
);
  localparam int unsigned PIX_W = CHANNELS * DATA_WIDTH;
  localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned COL_W = cnt_w(IMG_WIDTH);
  localparam int unsigned ROW_W = cnt_w(IMG_HEIGHT);
  localparam logic [CW-1:0]    TRDY_MAX = CW'(FIFO_DEPTH - PIPE_LATENCY - 2);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  typedef struct packed {
    logic             sof;
    logic [PIX_W-1:0] data;
  } pix_entry_t;

  if (FIFO_DEPTH < PIPE_LATENCY + 4) begin : g_depth_chk
    $error("FIFO_DEPTH must be at least PIPE_LATENCY+4");
  end
  if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_pow2_chk
    $error("FIFO_DEPTH must be a power of two");
  end

  pix_entry_t    wr_entry, head;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count, count_next;
  logic          pop, wr_ok, load;
  logic [COL_W-1:0] beat_col;
  logic [ROW_W-1:0] beat_row;

  out_state_t       state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [PIX_W-1:0] tdata_q, tdata_d;
  logic             tvalid_q, tvalid_d;
  logic             tuser_q, tuser_d;
  logic             tlast_q, tlast_d;
  logic             in_tready_q, in_tready_d;
  logic [CW-1:0]    fill_q, fill_d;
  logic             overflow_q, overflow_d;
  logic             frame_err_q, frame_err_d;

  assign wr_entry = {i_pix_sof, i_pix_data};

  median_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PIX_W + 1)
  ) u_fifo (
    .clk     (i_clk),
    .rst_n   (i_aresetn),
    .wr_en   (i_pix_valid),
    .wr_data (wr_entry),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Next-state for throttle, flags, sequencer, counters and output register.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q;
    tuser_d     = tuser_q;
    tlast_d     = tlast_q;
    overflow_d  = overflow_q;
    frame_err_d = frame_err_q;
    beat_col    = '0;
    beat_row    = '0;

    pop   = !fifo_empty && (!tvalid_q || m_axis.m_axis_tready);
    wr_ok = i_pix_valid && (!fifo_full || pop);
    // Headroom is judged on the post-update occupancy so the flag is exact at every edge.
    count_next  = fifo_count + CW'(wr_ok) - CW'(pop);
    fill_d      = count_next;
    in_tready_d = (count_next <= TRDY_MAX);

    if (i_pix_valid && !wr_ok) overflow_d = 1'b1;

    if (tvalid_q && m_axis.m_axis_tready) tvalid_d = 1'b0;

    // In WAIT_SOF a popped non-SOF entry is simply discarded.
    load = pop && ((state_q == STREAM) || head.sof);
    if (load) begin
      if ((state_q == STREAM) && !head.sof) begin
        beat_col = col_q;
        beat_row = row_q;
      end
      if ((state_q == STREAM) && head.sof && ((col_q != '0) || (row_q != '0)))
        frame_err_d = 1'b1;
      state_d  = STREAM;
      tvalid_d = 1'b1;
      tdata_d  = head.data;
      tuser_d  = (beat_col == '0) && (beat_row == '0);
      tlast_d  = (beat_col == COL_LAST);
      if (beat_col == COL_LAST) begin
        col_d = '0;
        row_d = (beat_row == ROW_LAST) ? '0 : beat_row + ROW_W'(1);
      end else begin
        col_d = beat_col + COL_W'(1);
        row_d = beat_row;
      end
    end
  end

  // State registers; reset discards any held beat and re-arms SOF search.
  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state_q     <= WAIT_SOF;
      col_q       <= '0;
      row_q       <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tuser_q     <= 1'b0;
      tlast_q     <= 1'b0;
      in_tready_q <= 1'b0;
      fill_q      <= '0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tuser_q     <= tuser_d;
      tlast_q     <= tlast_d;
      in_tready_q <= in_tready_d;
      fill_q      <= fill_d;
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign m_axis.m_axis_tdata  = tdata_q;
  assign m_axis.m_axis_tvalid = tvalid_q;
  assign m_axis.m_axis_tuser  = tuser_q;
  assign m_axis.m_axis_tlast  = tlast_q;
  assign o_in_tready          = in_tready_q;
  assign o_fill_level         = fill_q;
  assign o_overflow           = overflow_q;
  assign o_frame_err          = frame_err_q;

endmodule

// File: tb/tb_median_axis_out_backpressure.sv
// Scoreboard bench for the median output stage: a frame-level model predicts
// every output beat; a monitor compares beats as the DUT hands them over.
module tb_median_axis_out_backpressure;
  localparam int unsigned DW  = 8;
  localparam int unsigned CH  = 2;
  localparam int unsigned W   = 4;
  localparam int unsigned H   = 2;
  localparam int unsigned PL  = 6;
  localparam int unsigned FD  = 32;
  localparam int unsigned PW  = DW * CH;
  localparam int unsigned FLW = $clog2(FD) + 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_tready;
  logic [PW-1:0]  pix_data;
  logic           pix_valid;
  logic           pix_sof;
  logic [FLW-1:0] fill;
  logic           overflow;
  logic           frame_err;
  logic           tready;

  median_axis_out_backpressure_if #(.TDATA_W(PW)) axis ();
  assign axis.m_axis_tready = tready;

  median_axis_out_backpressure #(
    .DATA_WIDTH   (DW),
    .CHANNELS     (CH),
    .IMG_WIDTH    (W),
    .IMG_HEIGHT   (H),
    .PIPE_LATENCY (PL),
    .FIFO_DEPTH   (FD)
  ) dut (
    .i_clk        (clk),
    .i_aresetn    (rst_n),
    .o_in_tready  (in_tready),
    .i_pix_data   (pix_data),
    .i_pix_valid  (pix_valid),
    .i_pix_sof    (pix_sof),
    .m_axis       (axis.master),
    .o_fill_level (fill),
    .o_overflow   (overflow),
    .o_frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [PW-1:0] data;
    logic          tuser;
    logic          tlast;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  bit    synced;
  int    pos;
  bit    exp_frame_err;
  int    tready_mode = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: pos is the linear pixel index within the frame.
  task automatic model_pix(input logic [PW-1:0] d, input bit sof);
    beat_t b;
    if (sof) begin
      if (synced && pos != 0) exp_frame_err = 1'b1;
      synced = 1'b1;
      pos    = 0;
    end
    if (!synced) return;
    b.data  = d;
    b.tuser = (pos == 0);
    b.tlast = ((pos % W) == W - 1);
    exp_q.push_back(b);
    pos = (pos + 1) % (W * H);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_pix(input bit sof, input bit drop);
    logic [PW-1:0] d;
    d = PW'($urandom);
    pix_valid = 1'b1;
    pix_data  = d;
    pix_sof   = sof;
    if (!drop) model_pix(d, sof);
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic send_frame(input int n);
    for (int i = 0; i < n; i++) drive_pix(i == 0, 1'b0);
  endtask

  task automatic drain(input string name);
    int guard = 0;
    while (exp_q.size() != 0 && guard < 2000) begin
      @(posedge clk);
      guard++;
    end
    #1;
    idle(3);
    check(name, exp_q.size(), 0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    synced        = 1'b0;
    pos           = 0;
    exp_frame_err = 1'b0;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    model_reset();
    idle(2);
    check("rst_tvalid", axis.m_axis_tvalid, 0);
    check("rst_tuser", axis.m_axis_tuser, 0);
    check("rst_tlast", axis.m_axis_tlast, 0);
    check("rst_fill", fill, 0);
    check("rst_in_tready", in_tready, 0);
    check("rst_overflow", overflow, 0);
    check("rst_frame_err", frame_err, 0);
    rst_n = 1'b1;
    idle(1);
    check("in_tready_after_rst", in_tready, 1);
  endtask

  // Downstream ready: 0 = always, 1 = 1-0-0-1 pattern, 2 = random, 3 = never.
  bit [3:0] pat = 4'b1001;
  int       phase = 0;
  always @(posedge clk) begin
    #1;
    case (tready_mode)
      0:       tready = 1'b1;
      1: begin
        tready = pat[phase];
        phase  = (phase + 1) % 4;
      end
      2:       tready = 1'(($urandom % 2));
      default: tready = 1'b0;
    endcase
  end

  // Monitor: pop the scoreboard on each handshake, check hold during stalls.
  beat_t prev_beat;
  bit    prev_stall = 1'b0;
  always @(negedge clk) begin
    beat_t cur;
    beat_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      cur.data  = axis.m_axis_tdata;
      cur.tuser = axis.m_axis_tuser;
      cur.tlast = axis.m_axis_tlast;
      if (prev_stall) begin
        check("hold_valid", axis.m_axis_tvalid, 1);
        check("hold_beat", longint'(cur), longint'(prev_beat));
      end
      if (axis.m_axis_tvalid && tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", cur.data, e.data);
          check("beat_tuser", cur.tuser, e.tuser);
          check("beat_tlast", cur.tlast, e.tlast);
        end
      end
      prev_stall = axis.m_axis_tvalid && !tready;
      prev_beat  = cur;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_low;
    rst_n     = 1'b0;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_data  = '0;
    tready    = 1'b1;
    #1;
    do_reset();

    // Frame with free-flowing output; first tvalid two edges after first pixel.
    tready_mode = 0;
    drive_pix(1'b1, 1'b0);
    check("latency_edge1", axis.m_axis_tvalid, 0);
    drive_pix(1'b0, 1'b0);
    check("latency_edge2", axis.m_axis_tvalid, 1);
    for (int i = 2; i < 8; i++) drive_pix(1'b0, 1'b0);
    drain("t1_drain");

    // Same frame under a 1-0-0-1 ready pattern.
    tready_mode = 1;
    send_frame(8);
    drain("t2_drain");
    check("t2_overflow", overflow, 0);

    // Stalled output: throttle follows headroom, no loss.
    tready_mode = 3;
    saw_low = 1'b0;
    drive_pix(1'b1, 1'b0);
    for (int i = 0; i < 30; i++) begin
      drive_pix(1'b0, 1'b0);
      check("headroom", in_tready, (fill <= FD - PL - 2));
      if (!in_tready) saw_low = 1'b1;
    end
    check("t3_throttle_fell", saw_low, 1);
    check("t3_fill", fill, 30);
    check("t3_overflow", overflow, 0);
    tready_mode = 2;
    drain("t3_drain");

    // Overflow: output register held, 33 pixels into a 32-deep FIFO.
    do_reset();
    tready_mode = 3;
    drive_pix(1'b1, 1'b0);
    idle(2);
    for (int i = 1; i <= 33; i++) drive_pix(1'b0, i == 33);
    idle(1);
    check("t4_overflow", overflow, 1);
    check("t4_fill", fill, 32);
    tready_mode = 2;
    drain("t4_drain");
    check("t4_overflow_sticky", overflow, 1);

    // Pre-SOF pixels are discarded.
    do_reset();
    tready_mode = 2;
    for (int i = 0; i < 3; i++) drive_pix(1'b0, 1'b0);
    send_frame(8);
    drain("t5_drain");

    // Early SOF at (col 2, row 1) flags a frame error and resyncs.
    send_frame(6);
    drain("t6a_drain");
    check("t6_no_err_yet", frame_err, 0);
    send_frame(8);
    send_frame(8);
    drain("t6b_drain");
    check("t6_frame_err", frame_err, exp_frame_err);

    // Reset mid-frame with 10 entries buffered.
    do_reset();
    tready_mode = 3;
    drive_pix(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) drive_pix(1'b0, 1'b0);
    idle(2);
    check("t7_fill_before", fill, 10);
    check("t7_tvalid_before", axis.m_axis_tvalid, 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t7_tvalid", axis.m_axis_tvalid, 0);
    check("t7_fill", fill, 0);
    check("t7_in_tready", in_tready, 0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    tready_mode = 0;
    for (int i = 0; i < 2; i++) drive_pix(1'b0, 1'b0);
    send_frame(8);
    drain("t7_drain");
    check("t7_frame_err", frame_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
